// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, response and memory-pin bundle for dmem_arbiter
// Ports (slave = arbiter view):
//   req0_*/req1_*  valid, we, addr, wdata in; ready out
//   rsp0_valid/rsp1_valid, rsp_rdata  response out
//   mem_we, mem_a, mem_wd out; mem_rd in (combinational from mem_a)
//   busy out
interface dmem_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req0_valid, req0_we, req0_ready, rsp0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_we, req1_ready, rsp1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [DW-1:0] rsp_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          busy;
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, mem_rd,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rdata,
        output mem_we, mem_a, mem_wd, busy
    );
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, mem_rd,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rdata,
        input  mem_we, mem_a, mem_wd, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of a single-port data memory
// Ports: clk; rst (async, active-low); bus (dmem_arbiter_if.slave) carrying both
//   requester handshakes, the one-cycle response pulses with rsp_rdata, the
//   registered memory pins mem_we/mem_a/mem_wd, mem_rd and busy.
// Option: DMEM_ARB_RR_EN selects round-robin arbitration; otherwise requester 0
//   has fixed priority.
module dmem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
    logic [1:0]    state;
    logic          gnt, win1, idle;
    logic          mem_we_q, rsp0_q, rsp1_q;
    logic [AW-1:0] mem_a_q;
    logic [DW-1:0] mem_wd_q, rdata_q;
`ifdef DMEM_ARB_RR_EN
    logic rr_last;
    always_ff @(posedge clk or negedge rst)
        if (!rst) rr_last <= 1'b1;
        else if (state == RESP) rr_last <= gnt;
    // on contention the requester that was not served last wins
    assign win1 = bus.req1_valid & (~bus.req0_valid | ~rr_last);
`else
    assign win1 = bus.req1_valid & ~bus.req0_valid;
`endif
    assign idle           = state == IDLE;
    assign bus.req0_ready = idle & bus.req0_valid & ~win1;
    assign bus.req1_ready = idle & win1;
    assign bus.busy       = ~idle;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = mem_wd_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;
    assign bus.rsp_rdata  = rdata_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= '0;
            mem_wd_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req0_valid | bus.req1_valid) begin
                    gnt      <= win1;
                    mem_we_q <= win1 ? bus.req1_we    : bus.req0_we;
                    mem_a_q  <= win1 ? bus.req1_addr  : bus.req0_addr;
                    mem_wd_q <= win1 ? bus.req1_wdata : bus.req0_wdata;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // a write leaves the previous read data on rsp_rdata
                    if (!mem_we_q) rdata_q <= bus.mem_rd;
                    mem_we_q <= 1'b0;
                    rsp0_q   <= ~gnt;
                    rsp1_q   <= gnt;
                    state    <= RESP;
                end
                RESP: begin
                    rsp0_q <= 1'b0;
                    rsp1_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
